// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_ctrl
// Description : Bit-serial ALU. It processes one operand bit per clock, LSB
//               first, through a single full-adder slice. It covers the
//               logic ops, ADD, SUB and a signed set-less-than. Results and
//               flags hold until the next request is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    localparam logic [1:0] c_s_idle    = 2'd0;
    localparam logic [1:0] c_s_run     = 2'd1;
    localparam logic [1:0] c_s_slt_fix = 2'd2;
    localparam logic [1:0] c_s_done    = 2'd3;

    localparam logic [2:0] c_op_and  = 3'b000;
    localparam logic [2:0] c_op_or   = 3'b001;
    localparam logic [2:0] c_op_add  = 3'b010;
    localparam logic [2:0] c_op_nand = 3'b011;
    localparam logic [2:0] c_op_nor  = 3'b100;
    localparam logic [2:0] c_op_addn = 3'b101;
    localparam logic [2:0] c_op_sub  = 3'b110;

    logic [1:0]       r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_carry, w_carry_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_zero, w_zero_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_cout, w_cout_nxt;
    logic             r_cin_msb, w_cin_msb_nxt;
    logic             r_cout_msb, w_cout_msb_nxt;
    logic             r_sum_msb, w_sum_msb_nxt;

    logic [IW-1:0] w_idx;
    logic          w_accept, w_last;
    logic          w_binv, w_a_bit, w_b_bit, w_bm, w_sum, w_bit_cout, w_bit;
    logic          w_slt_bit;

    assign start_ready = (r_state == c_s_idle);
    assign busy        = (r_state == c_s_run) || (r_state == c_s_slt_fix);
    assign done        = (r_state == c_s_done);
    assign result      = r_result;
    assign zero        = r_zero;
    assign overflow    = r_ovf;
    assign carry_out   = r_cout;

    assign w_accept  = start_valid && (r_state == c_s_idle);
    assign w_last    = (r_cnt == c_last);
    assign w_idx     = r_cnt[IW-1:0];
    assign w_slt_bit = r_sum_msb ^ (r_cin_msb ^ r_cout_msb);

    // Single-bit slice: b is inverted for SUB/SLT, carry seeded with binv at accept
    always_comb begin
        w_binv     = r_op[2] & r_op[1];
        w_a_bit    = r_a[w_idx];
        w_b_bit    = r_b[w_idx];
        w_bm       = w_b_bit ^ w_binv;
        w_sum      = w_a_bit ^ w_bm ^ r_carry;
        w_bit_cout = (w_a_bit & w_bm) | ((w_a_bit ^ w_bm) & r_carry);
        case (r_op)
            c_op_and:  w_bit = w_a_bit & w_b_bit;
            c_op_or:   w_bit = w_a_bit | w_b_bit;
            c_op_nand: w_bit = ~(w_a_bit & w_b_bit);
            c_op_nor:  w_bit = ~(w_a_bit | w_b_bit);
            c_op_add, c_op_addn, c_op_sub: w_bit = w_sum;
            default:   w_bit = 1'b0;
        endcase
    end

    // Next-state and datapath update; every register holds unless its state acts on it
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_carry_nxt    = r_carry;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_op_nxt       = r_op;
        w_result_nxt   = r_result;
        w_zero_nxt     = r_zero;
        w_ovf_nxt      = r_ovf;
        w_cout_nxt     = r_cout;
        w_cin_msb_nxt  = r_cin_msb;
        w_cout_msb_nxt = r_cout_msb;
        w_sum_msb_nxt  = r_sum_msb;
        case (r_state)
            c_s_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_s_run;
                    w_cnt_nxt   = '0;
                    w_carry_nxt = op[2] & op[1];
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_op_nxt    = op;
                end
            end
            c_s_run: begin
                w_result_nxt[w_idx] = w_bit;
                w_carry_nxt         = w_bit_cout;
                w_cnt_nxt           = r_cnt + CW'(1);
                if (w_last) begin
                    w_cin_msb_nxt  = r_carry;
                    w_cout_msb_nxt = w_bit_cout;
                    w_sum_msb_nxt  = w_sum;
                    if (r_op == 3'b111) begin
                        w_state_nxt = c_s_slt_fix;
                    end else begin
                        w_state_nxt = c_s_done;
                        w_zero_nxt  = (w_result_nxt == '0);
                        w_ovf_nxt   = ((r_op == c_op_add) || (r_op == c_op_sub))
                                      && (r_carry ^ w_bit_cout);
                        w_cout_nxt  = ((r_op == c_op_add) || (r_op == c_op_addn)
                                      || (r_op == c_op_sub)) && w_bit_cout;
                    end
                end
            end
            c_s_slt_fix: begin
                // Signed less-than: sign of a-b corrected by the overflow condition
                w_result_nxt    = '0;
                w_result_nxt[0] = w_slt_bit;
                w_zero_nxt      = ~w_slt_bit;
                w_ovf_nxt       = 1'b0;
                w_cout_nxt      = 1'b0;
                w_state_nxt     = c_s_done;
            end
            default: begin
                w_state_nxt = c_s_idle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_s_idle;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_cout     <= 1'b0;
            r_cin_msb  <= 1'b0;
            r_cout_msb <= 1'b0;
            r_sum_msb  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_carry    <= w_carry_nxt;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_op       <= w_op_nxt;
            r_result   <= w_result_nxt;
            r_zero     <= w_zero_nxt;
            r_ovf      <= w_ovf_nxt;
            r_cout     <= w_cout_nxt;
            r_cin_msb  <= w_cin_msb_nxt;
            r_cout_msb <= w_cout_msb_nxt;
            r_sum_msb  <= w_sum_msb_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/alu_serial_ctrl.md
ALU_SERIAL_CTRL -- requirements
Module: alu_serial_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, 32, the operand and result width, legal range 2..64.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start_valid  input  1  the request strobe.
REQ-005 The block SHALL have port start_ready  output  1  high when a request can be accepted.
REQ-006 The block SHALL have port op  input  3  the operation: 000 AND, 001 OR, 010 ADD, 011 NAND, 100 NOR, 101 ADD-no-flags, 110 SUB, 111 SLT.
REQ-007 The block SHALL have ports a and b  input  WIDTH  the operands.
REQ-008 The block SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 The block SHALL have port done  output  1  a one-cycle pulse marking result and flags valid.
REQ-010 The block SHALL have port result  output  WIDTH  the operation result.
REQ-011 The block SHALL have ports zero, overflow and carry_out  output  1 each  the status flags.

Function
REQ-012 Accept SHALL occur on a rising edge with start_valid=1 and start_ready=1 (edge E0); a, b and op are latched at E0, and later input changes are ignored until the next accept.
REQ-013 The FSM SHALL have states IDLE, RUN, SLT_FIX and DONE; start_ready=1 only in IDLE; busy=1 in RUN and SLT_FIX.
REQ-014 Transitions SHALL be: IDLE->RUN on accept; RUN->DONE at bit counter WIDTH-1, or RUN->SLT_FIX if op=111; SLT_FIX->DONE; DONE->IDLE unconditionally.
REQ-015 RUN SHALL process one bit per cycle, LSB first: bit i is computed in the cycle after edge Ei and is registered at edge E(i+1); the bit counter is log2(WIDTH)+1 bits wide and clears on accept.
REQ-016 The per-bit datapath SHALL be: binv = op[2]&op[1]; bm = b[i]^binv; sum = a[i]^bm^c; cout = a[i]&bm | (a[i]^bm)&c; the carry register is loaded with binv at accept and with cout each RUN cycle.
REQ-017 The per-bit result SHALL be: AND a&b, OR a|b, NAND ~(a&b), NOR ~(a|b), ADD/101/SUB sum, SLT 0; logic ops use unmodified b.
REQ-018 In the MSB cycle the block SHALL capture cin_msb (carry before the MSB), cout_msb, and sum_msb.
REQ-019 For SLT, SLT_FIX SHALL write result[0] = sum_msb ^ (cin_msb ^ cout_msb), giving a true signed less-than; all other result bits SHALL be 0.
REQ-020 The block SHALL set overflow = cin_msb^cout_msb for op 010 and 110 only, and 0 for all other ops including 101 and 111.
REQ-021 The block SHALL set carry_out = cout_msb for op 010, 101 and 110, and 0 otherwise.
REQ-022 zero SHALL equal 1 exactly when the final result equals all zeros (SLT included).
REQ-023 done SHALL be 1 only in DONE: at the first cycle after edge E(WIDTH) for non-SLT ops, and after edge E(WIDTH+1) for SLT.
REQ-024 result, zero, overflow and carry_out SHALL be valid while done=1 and SHALL hold until the next accept; they are not cleared at accept, and intermediate result bits may be visible during RUN.
REQ-025 Minimum request spacing SHALL be WIDTH+2 cycles for non-SLT ops and WIDTH+3 cycles for SLT; start_valid during RUN, SLT_FIX or DONE SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL force, asynchronously: state=IDLE, bit counter=0, carry=0, result=0, zero=0, overflow=0, carry_out=0, done=0, busy=0, start_ready=1.
REQ-027 Reset asserted in any state, including mid-RUN, SLT_FIX or DONE, SHALL abort the operation with no done pulse.
REQ-028 After rst_n deasserts, the block SHALL accept a new request on the first rising edge.

Verification (WIDTH=32)
REQ-029 ADD a=0x7FFFFFFF, b=0x00000001 -> done after E32; result=0x80000000, overflow=1, carry_out=0, zero=0.
REQ-030 SUB a=5, b=5 -> result=0, zero=1, carry_out=1, overflow=0; a second request issued at the first legal cycle is accepted.
REQ-031 SLT a=0x80000000, b=1 -> result=1, done after E33; SLT a=0x7FFFFFFF, b=0xFFFFFFFF -> result=0 (overflow case); overflow=0 in both cases.
REQ-032 NOR a=0xF0F0F0F0, b=0x0F0F0F00 -> result=0x0000000F, carry_out=0, overflow=0; op 101 with a=b=0xFFFFFFFF -> result=0xFFFFFFFE, carry_out=1, overflow=0.
REQ-033 Reset pulsed at bit 10 of an ADD -> all outputs at reset values with no done pulse; the next ADD 3+4 -> result=7.
REQ-034 start_valid held high with a and b toggling every cycle during RUN -> start_ready=0 throughout and the result is computed from the operands latched at E0.
